sm4_round_key_store: RTL
========================

Name: sm4_round_key_store

Overview:
Consumer end of the key-expansion output stream: captures the 32 SM4 round keys rk0..rk31 as they arrive one per valid pulse. It stores them and replays them to the round engine in a single-cycle-per-key stream. Order is forward for encryption and reverse (rk31..rk0) for decryption. Sits between the key expander and the SM4 round datapath, so a key is expanded once and reused for many blocks.

Parameters:
RK_NUM, 32, number of round keys stored (fixed SM4 value; index width 5 bits)
RK_WIDTH, 32, width of one round key

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  asynchronous active-high reset
i_load_start  input  1  pulse: discard stored keys, begin capturing a new key schedule
i_Encrypt_Key  input  RK_WIDTH  round key word from expander
i_Encrypt_valid  input  1  qualifies i_Encrypt_Key; one word per high cycle, in order rk0..rk31
i_rd_start  input  1  pulse: begin replay of the 32 stored keys
i_decrypt  input  1  sampled with i_rd_start: 0 = forward order, 1 = reverse order
i_rd_en  input  1  advance replay by one key this cycle (stall when low)
o_round_key  output  RK_WIDTH  replayed round key
o_round_key_valid  output  1  qualifies o_round_key
o_round_idx  output  5  round number 0..31 of the current output (0 = first round applied)
o_keys_ready  output  1  full schedule stored, replay permitted
o_busy  output  1  high in LOAD or READ
o_error  output  1  sticky protocol error flag, cleared only by i_load_start or reset

Behaviour:
- Reset: state IDLE; all counters 0; o_round_key 0; o_round_key_valid, o_keys_ready, o_busy, o_error 0.
- States: IDLE, LOAD, READY, READ.
- IDLE: i_Encrypt_valid ignored. i_rd_start sets o_error. i_load_start -> LOAD.
- LOAD: each i_Encrypt_valid writes the word to entry wr_cnt; wr_cnt increments. Write of entry 31 -> READY next cycle; o_keys_ready rises the same edge.
- READY: o_keys_ready=1. i_rd_start -> READ; latch i_decrypt into dir flag; rd_cnt=0. i_Encrypt_valid in READY is ignored and sets o_error.
- READ: on a cycle with i_rd_en=1, read address = rd_cnt (forward) or 31-rd_cnt (reverse). o_round_key/o_round_key_valid/o_round_idx are registered one cycle later (latency 1). o_round_idx = rd_cnt. rd_cnt increments.
- READ with i_rd_en=0: o_round_key_valid=0 next cycle, o_round_key holds its last value, no advance.
- After the rd_cnt=31 issue, return to READY. Keys are retained; unlimited replays allowed.
- i_rd_start during READ: ignored, sets o_error.
- i_load_start in any state, including mid-LOAD or mid-READ: takes priority over every other input that cycle. Aborts the current operation, wr_cnt=0, o_keys_ready=0, o_round_key_valid=0 next cycle, o_error cleared -> LOAD. An i_Encrypt_valid in the same cycle is NOT captured.
- i_decrypt is sampled only at i_rd_start; changes during READ have no effect.
- Counters are 5 bits. Wrap never occurs, because state transitions at 31.
- Asynchronous reset mid-operation: immediate return to reset values; stored keys are not guaranteed (see optional feature).

Optional Feature:
- SM4_RK_CLEAR_EN defined:
  - Storage is 32 flop registers.
  - Cleared to 0 on i_rst and on i_load_start.
  - Replay after an aborted LOAD can never expose stale key material.
- Not defined:
  - Storage has no reset or clear and may map to distributed RAM.
  - Contents are undefined until rewritten; access is gated only by o_keys_ready.
- Port list and timing are identical either way.

Test Plan:
- Reset, i_load_start, then stream the expansion of key 0123456789ABCDEFFEDCBA9876543210 -> o_keys_ready rises the edge after the 32nd word, o_busy falls.
- i_rd_start with i_decrypt=0, i_rd_en held 1 -> 32 consecutive valid outputs, first F12186F9 idx 0, last 9124A012 idx 31, then READY.
- i_rd_start with i_decrypt=1 -> first output 9124A012 idx 0, last F12186F9 idx 31.
- Forward replay, i_rd_en toggled 1,0,0,1 -> valid gaps match the low cycles, keys unskipped and unduplicated, total 32.
- i_load_start at replay idx 10 -> o_round_key_valid low next cycle, o_keys_ready 0, a concurrent valid word is dropped, 32 new words reload correctly.
- Extra i_Encrypt_valid in READY, or i_rd_start in IDLE -> o_error=1, stored keys unchanged. Next i_load_start clears o_error. With SM4_RK_CLEAR_EN, a store after an aborted load reads 0.

Source files
------------

// File: rtl/sm4_round_key_store_if.sv
// Handshake bundle between the SM4 key expander / round engine and the round-key store.
// The master side drives the i_* signals, the store (slave) drives the o_* signals.
interface sm4_round_key_store_if #(
  parameter int RK_WIDTH = 32
);
  logic                i_load_start;
  logic [RK_WIDTH-1:0] i_Encrypt_Key;
  logic                i_Encrypt_valid;
  logic                i_rd_start;
  logic                i_decrypt;
  logic                i_rd_en;
  logic [RK_WIDTH-1:0] o_round_key;
  logic                o_round_key_valid;
  logic [4:0]          o_round_idx;
  logic                o_keys_ready;
  logic                o_busy;
  logic                o_error;

  modport master (
    output i_load_start, i_Encrypt_Key, i_Encrypt_valid, i_rd_start, i_decrypt, i_rd_en,
    input  o_round_key, o_round_key_valid, o_round_idx, o_keys_ready, o_busy, o_error
  );

  modport slave (
    input  i_load_start, i_Encrypt_Key, i_Encrypt_valid, i_rd_start, i_decrypt, i_rd_en,
    output o_round_key, o_round_key_valid, o_round_idx, o_keys_ready, o_busy, o_error
  );
endinterface

// File: rtl/sm4_round_key_store.sv
// Captures the 32 SM4 round keys from the expander and replays them forward (encrypt) or
// reversed (decrypt), one key per enabled cycle. Define SM4_RK_CLEAR_EN to clear storage on reset/reload.
module sm4_round_key_store #(
  parameter int RK_NUM   = 32,
  parameter int RK_WIDTH = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  sm4_round_key_store_if.slave bus
);
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RK_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY, READ} state_t;

  state_t              state;
  logic [IDX_W-1:0]    wr_cnt;
  logic [IDX_W-1:0]    rd_cnt;
  logic                dir;
  logic [RK_WIDTH-1:0] mem [RK_NUM];
  logic                wr_en;
  logic [IDX_W-1:0]    rd_addr;

  // A reload request wins over a word arriving in the same cycle, so that word is dropped.
  assign wr_en   = (state == LOAD) && bus.i_Encrypt_valid && !bus.i_load_start;
  assign rd_addr = dir ? (LAST_IDX - rd_cnt) : rd_cnt;

`ifdef SM4_RK_CLEAR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem <= '{default: '0};
    end else if (bus.i_load_start) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_cnt] <= bus.i_Encrypt_Key;
    end
  end
`else
  // NOTE: storage deliberately has no reset so it can map to distributed RAM;
  // o_keys_ready is the only guard against reading stale entries.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_cnt] <= bus.i_Encrypt_Key;
    end
  end
`endif

  // NOTE: every state and output register is assigned with <= so all of them
  // update together from the values sampled at this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                 <= IDLE;
      wr_cnt                <= '0;
      rd_cnt                <= '0;
      dir                   <= 1'b0;
      bus.o_round_key       <= '0;
      bus.o_round_key_valid <= 1'b0;
      bus.o_round_idx       <= '0;
      bus.o_keys_ready      <= 1'b0;
      bus.o_busy            <= 1'b0;
      bus.o_error           <= 1'b0;
    end else begin
      bus.o_round_key_valid <= 1'b0;
      if (bus.i_load_start) begin
        state            <= LOAD;
        wr_cnt           <= '0;
        rd_cnt           <= '0;
        bus.o_keys_ready <= 1'b0;
        bus.o_busy       <= 1'b1;
        bus.o_error      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_rd_start) bus.o_error <= 1'b1;
          end
          LOAD: begin
            if (bus.i_Encrypt_valid) begin
              if (wr_cnt == LAST_IDX) begin
                state            <= READY;
                wr_cnt           <= '0;
                bus.o_keys_ready <= 1'b1;
                bus.o_busy       <= 1'b0;
              end else begin
                wr_cnt <= wr_cnt + 1'b1;
              end
            end
          end
          READY: begin
            if (bus.i_Encrypt_valid) bus.o_error <= 1'b1;
            if (bus.i_rd_start) begin
              state      <= READ;
              dir        <= bus.i_decrypt;
              rd_cnt     <= '0;
              bus.o_busy <= 1'b1;
            end
          end
          READ: begin
            if (bus.i_rd_start) bus.o_error <= 1'b1;
            if (bus.i_rd_en) begin
              bus.o_round_key       <= mem[rd_addr];
              bus.o_round_key_valid <= 1'b1;
              bus.o_round_idx       <= rd_cnt;
              if (rd_cnt == LAST_IDX) begin
                state      <= READY;
                rd_cnt     <= '0;
                bus.o_busy <= 1'b0;
              end else begin
                rd_cnt <= rd_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
